// File: rtl/dbg_scan_bridge.sv
// Sysclk-side debug scan bridge: serial DR shift/capture, update-DR to valid/ready
// command hand-off, per-IR take_action/take_no_action decode and sticky overrun flag.
module dbg_scan_bridge #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_ir,
  input  logic [IR_W-1:0]      ir_value,
  input  logic                 cap_dr,
  input  logic                 shift_dr,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic                 upd_dr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DATA_W-1:0]    jdo,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int NUM_IR = 2**IR_W;

  typedef enum logic [1:0] {IDLE, SHIFT, PEND} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   sr;
  logic [IR_W-1:0]     ir_q;
  logic                accept;
  logic                load;
  logic                drop;
  logic [NUM_IR-1:0]   sel;

  // cmd_valid is purely a decode of the state register, so cmd_ready never reaches it
  assign cmd_valid = (state == PEND);
  assign accept    = cmd_valid & cmd_ready;
  assign load      = upd_dr & (~cmd_valid | cmd_ready);
  assign drop      = upd_dr & cmd_valid & ~cmd_ready;
  assign tdo       = sr[0];
  assign sel       = NUM_IR'(1) << cmd_ir;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (upd_dr) begin
          state_next = PEND;
        end else if (cap_dr || shift_dr) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (upd_dr) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (accept && !upd_dr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture wins over shift; upd_dr sees sr before this cycle's shift
  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      ir_q <= '0;
    end else begin
      if (cap_dr) begin
        sr <= rd_data;
      end else if (shift_dr) begin
        sr <= {tdi, sr[DATA_W-1:1]};
      end
      if (upd_ir) begin
        ir_q <= ir_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo    <= '0;
      cmd_ir <= '0;
    end else if (load) begin
      jdo    <= sr;
      cmd_ir <= ir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  // Decode uses the command being accepted, before any same-cycle replacement lands
  always_ff @(posedge clk) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (accept &&  jdo[DATA_W-1]) ? sel : '0;
      take_no_action <= (accept && !jdo[DATA_W-1]) ? sel : '0;
    end
  end

endmodule

// File: tb/tb_dbg_scan_bridge.sv
// Scoreboard bench for dbg_scan_bridge: directed scan scenarios plus random traffic
// against a bit-level reference model, and a small-parameter build check.
module tb_dbg_scan_bridge;

  localparam int DW = 38;
  localparam int IW = 2;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset, upd_ir, cap_dr, shift_dr, tdi, tdo, upd_dr;
  logic [IW-1:0] ir_value, cmd_ir;
  logic [DW-1:0] rd_data, jdo;
  logic          cmd_valid, cmd_ready, overrun, overrun_clr;
  logic [NI-1:0] take_action, take_no_action;

  logic          s_reset, s_upd_ir, s_cap_dr, s_shift_dr, s_tdi, s_tdo, s_upd_dr;
  logic [2:0]    s_ir_value, s_cmd_ir;
  logic [15:0]   s_rd_data, s_jdo;
  logic          s_cmd_valid, s_cmd_ready, s_overrun, s_overrun_clr;
  logic [7:0]    s_take_action, s_take_no_action;

  always #5 clk = ~clk;

  dbg_scan_bridge #(.DATA_W(DW), .IR_W(IW)) dut (
    .clk(clk), .reset(reset), .upd_ir(upd_ir), .ir_value(ir_value), .cap_dr(cap_dr),
    .shift_dr(shift_dr), .tdi(tdi), .tdo(tdo), .upd_dr(upd_dr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  dbg_scan_bridge #(.DATA_W(16), .IR_W(3)) dut16 (
    .clk(clk), .reset(s_reset), .upd_ir(s_upd_ir), .ir_value(s_ir_value), .cap_dr(s_cap_dr),
    .shift_dr(s_shift_dr), .tdi(s_tdi), .tdo(s_tdo), .upd_dr(s_upd_dr), .rd_data(s_rd_data),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ir(s_cmd_ir), .jdo(s_jdo),
    .take_action(s_take_action), .take_no_action(s_take_no_action), .overrun(s_overrun),
    .overrun_clr(s_overrun_clr)
  );

  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] data;
  } cmd_t;

  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] m_sr;
  logic [IW-1:0] m_irq;
  bit            m_pending;
  bit            m_ovr;
  cmd_t          exp_q[$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the values the DUT just sampled
  task automatic model_step();
    bit   accept;
    cmd_t c;
    if (reset) begin
      m_sr = '0;
      m_irq = '0;
      m_pending = 1'b0;
      m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      accept = m_pending && cmd_ready;
      if (upd_dr && m_pending && !accept) begin
        m_ovr = 1'b1;
      end else begin
        if (overrun_clr) m_ovr = 1'b0;
        if (upd_dr) begin
          c.ir = m_irq;
          c.data = m_sr;
          exp_q.push_back(c);
          m_pending = 1'b1;
        end else if (accept) begin
          m_pending = 1'b0;
        end
      end
      if (cap_dr) m_sr = rd_data;
      else if (shift_dr) m_sr = {tdi, m_sr[DW-1:1]};
      if (upd_ir) m_irq = ir_value;
    end
  endtask

  task automatic apply_stimulus(input bit a_reset, input bit a_cap, input bit a_shift,
                                input bit a_tdi, input bit a_upd_dr, input bit a_upd_ir,
                                input logic [IW-1:0] a_ir, input logic [DW-1:0] a_rd,
                                input bit a_ready, input bit a_oclr);
    reset = a_reset;
    cap_dr = a_cap;
    shift_dr = a_shift;
    tdi = a_tdi;
    upd_dr = a_upd_dr;
    upd_ir = a_upd_ir;
    ir_value = a_ir;
    rd_data = a_rd;
    cmd_ready = a_ready;
    overrun_clr = a_oclr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input bit a_ready);
    apply_stimulus(0, 0, 0, 0, 0, 0, '0, '0, a_ready, 0);
  endtask

  // Monitor: per-cycle comparison against the model, popping the scoreboard on accepts
  initial begin
    logic [NI-1:0] due_act, due_noact;
    cmd_t c;
    due_act = '0;
    due_noact = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_output("take_action", take_action, due_act);
        check_output("take_no_action", take_no_action, due_noact);
        check_output("cmd_valid", cmd_valid, m_pending);
        check_output("overrun", overrun, m_ovr);
        check_output("tdo", tdo, m_sr[0]);
        due_act = '0;
        due_noact = '0;
        if (!reset && m_pending && cmd_ready) begin
          if (exp_q.size() == 0) begin
            check_output("scoreboard_empty", 1, 0);
          end else begin
            c = exp_q.pop_front();
            check_output("jdo", jdo, c.data);
            check_output("cmd_ir", cmd_ir, c.ir);
            if (c.data[DW-1]) due_act = NI'(1) << c.ir;
            else due_noact = NI'(1) << c.ir;
          end
        end
      end else begin
        due_act = '0;
        due_noact = '0;
      end
    end
  end

  initial begin
    logic [DW-1:0] pat;
    logic [15:0]   pat16;
    {s_reset, s_upd_ir, s_cap_dr, s_shift_dr, s_tdi, s_upd_dr, s_cmd_ready, s_overrun_clr} = '0;
    s_ir_value = '0;
    s_rd_data = '0;
    s_reset = 1'b1;

    apply_stimulus(1, 0, 0, 0, 0, 0, '0, '0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, '0, '0, 0, 0);
    mon_en = 1'b1;
    check_output("reset_jdo", jdo, 0);
    check_output("reset_cmd_ir", cmd_ir, 0);
    check_output("reset_cmd_valid", cmd_valid, 0);
    check_output("reset_tdo", tdo, 0);

    // Scenario: IR = 2, shift in a command with the action bit set, accept it
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'd2, '0, 0, 0);
    pat = 38'h20_0000_00AB;
    for (int i = 0; i < DW; i++) apply_stimulus(0, 0, 1, pat[i], 0, 0, '0, '0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 0, 0);
    check_output("s1_jdo", jdo, 38'h20_0000_00AB);
    check_output("s1_cmd_ir", cmd_ir, 2);
    idle(1);
    check_output("s1_take_action", take_action, 4'b0100);
    idle(0);
    idle(0);

    // Scenario: capture then shift out; capture and shift together
    apply_stimulus(0, 1, 0, 0, 0, 0, '0, 38'h15_5555_5555, 0, 0);
    for (int i = 0; i < DW; i++) apply_stimulus(0, 0, 1, 1'b0, 0, 0, '0, '0, 0, 0);
    apply_stimulus(0, 1, 1, 1, 0, 0, '0, 38'h2A_AAAA_AAAA, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 0, 0);
    idle(1);
    idle(0);

    // Scenario: second update while pending drops it and sets overrun
    pat = 38'h3F_0F0F_0F0F;
    apply_stimulus(0, 1, 0, 0, 0, 1, 2'd1, pat, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, '0, 38'h01_2345_6789, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 0, 0);
    check_output("s3_overrun", overrun, 1);
    check_output("s3_jdo_kept", jdo, pat);
    idle(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, '0, '0, 0, 1);
    check_output("s3_overrun_clr", overrun, 0);

    // Scenario: back-to-back commands with update coinciding with accept
    apply_stimulus(0, 1, 0, 0, 0, 1, 2'd0, '0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 1, 0);
    check_output("s4_valid_held", cmd_valid, 1);
    idle(1);
    check_output("s4_second_pulse", take_no_action, 4'b0001);
    idle(0);

    // Scenario: reset with a command pending mid-shift
    apply_stimulus(0, 1, 0, 0, 0, 0, '0, 38'h3F_FFFF_FFFF, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 1, 1'b1, 0, 0, '0, '0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, '0, '0, 1, 0);
    check_output("s5_cmd_valid", cmd_valid, 0);
    check_output("s5_jdo", jdo, 0);
    check_output("s5_take", {take_action, take_no_action}, 0);
    check_output("s5_tdo", tdo, 0);
    idle(1);
    check_output("s5_take_after", {take_action, take_no_action}, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 1) == 1), 1'($urandom), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 9) == 0), 2'($urandom), 38'({$urandom, $urandom}),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end
    idle(0);
    mon_en = 1'b0;

    // Small build: IR_W = 3, DATA_W = 16
    @(posedge clk); #1;
    s_reset = 1'b0;
    s_upd_ir = 1'b1;
    s_ir_value = 3'd7;
    @(posedge clk); #1;
    s_upd_ir = 1'b0;
    pat16 = 16'h8001;
    for (int i = 0; i < 16; i++) begin
      s_shift_dr = 1'b1;
      s_tdi = pat16[i];
      @(posedge clk); #1;
    end
    s_shift_dr = 1'b0;
    s_upd_dr = 1'b1;
    @(posedge clk); #1;
    s_upd_dr = 1'b0;
    check_output("w16_cmd_valid", s_cmd_valid, 1);
    check_output("w16_jdo", s_jdo, 16'h8001);
    check_output("w16_cmd_ir", s_cmd_ir, 7);
    s_cmd_ready = 1'b1;
    @(posedge clk); #1;
    s_cmd_ready = 1'b0;
    check_output("w16_take_action", s_take_action, 8'h80);
    check_output("w16_take_no_action", s_take_no_action, 8'h00);
    @(posedge clk); #1;
    check_output("w16_take_single", s_take_action, 8'h00);
    check_output("w16_cmd_valid_low", s_cmd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
